// File: rtl/bus_source_arbiter_pkg.sv
// Shared definitions for the bus source arbiter: FSM state encoding, source
// count, mux select width and small round-robin helper functions.
package bus_source_arbiter_pkg;

  // Number of requesters sharing the 6-input source mux.
  localparam int unsigned NUM_SRC = 6;

  // Width of the mux select / source index.
  localparam int unsigned SEL_W = 3;

  // Width of the tenure hold counter (MAX_HOLD legal range 2..15).
  localparam int unsigned HOLD_W = 4;

  // Arbiter FSM states; TURN is the one-cycle bus turnaround.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Source index following idx in round-robin order, wrapping 5 -> 0.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] idx);
    if (idx >= SEL_W'(NUM_SRC - 1)) begin
      return '0;
    end
    return idx + SEL_W'(1);
  endfunction

  // One-hot grant vector for a source index.
  function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SEL_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_source_arbiter_rr_pick6.sv
// rr_pick6: combinational round-robin priority search over six requesters.
//   req   - request vector, bit i = source i
//   start - index where the search begins; values 6/7 are treated as 0
//   valid - at least one request bit is set
//   idx   - first set request at or after start, wrapping 5 -> 0
module rr_pick6
  import bus_source_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] base;

  assign base = (start >= SEL_W'(NUM_SRC)) ? '0 : start;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    logic [SEL_W-1:0] cand;
    valid = 1'b0;
    idx   = base;
    cand  = '0;
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      cand = SEL_W'((int'(base) + k) % int'(NUM_SRC));
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter: round-robin owner selection for a shared 6-input
// 16-bit source mux, with a bounded tenure and a one-cycle turnaround.
//   clk     - single clock, rising edge
//   rst     - asynchronous active-high reset
//   req     - per-source request (bit i = mux input i)
//   rel     - single-cycle release from the current owner (GRANT only)
//   sel     - registered mux select, changes only on entry to GRANT
//   gnt     - registered one-hot grant, zero when there is no owner
//   busy    - high while in GRANT
//   timeout - one-cycle pulse when a tenure is ended by MAX_HOLD
module bus_source_arbiter #(
  parameter int unsigned NUM_SRC  = bus_source_arbiter_pkg::NUM_SRC,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_SRC-1:0]                      req,
  input  logic                                    rel,
  output logic [bus_source_arbiter_pkg::SEL_W-1:0] sel,
  output logic [NUM_SRC-1:0]                      gnt,
  output logic                                    busy,
  output logic                                    timeout
);

  import bus_source_arbiter_pkg::*;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state;
  logic [SEL_W-1:0]  last_owner;
  logic [HOLD_W-1:0] hold_cnt;

  logic [SEL_W-1:0]  start_idx;
  logic              pick_valid;
  logic [SEL_W-1:0]  pick_idx;
  logic              owner_req;
  logic              hold_expired;
  logic              end_tenure;

  // Search begins just past the previous owner so every requester gets a turn.
  assign start_idx = rr_next(last_owner);

  rr_pick6 u_pick (
    .req   (req),
    .start (start_idx),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // In GRANT last_owner is the current owner; other req bits are ignored.
  assign owner_req    = req[last_owner];
  assign hold_expired = (hold_cnt == HOLD_LAST);
  assign end_tenure   = rel || !owner_req || hold_expired;

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= SEL_W'(NUM_SRC - 1);
      hold_cnt   <= '0;
      sel        <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE, TURN: begin
          if (pick_valid) begin
            state      <= GRANT;
            gnt        <= src_onehot(pick_idx);
            sel        <= pick_idx;
            last_owner <= pick_idx;
            busy       <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (end_tenure) begin
            state    <= TURN;
            gnt      <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            // Only a pure hold expiry counts as a timeout.
            timeout  <= hold_expired && !rel && owner_req;
          end else if (!hold_expired) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed self-checking bench for bus_source_arbiter. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_bus_source_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] req = '0;
  logic       rel = 1'b0;
  logic [2:0] sel;
  logic [5:0] gnt;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  bus_source_arbiter #(.NUM_SRC(6), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Check all four outputs at once.
  task automatic check_out(input string tag, input logic [5:0] eg, input logic [2:0] es,
                           input logic eb, input logic et);
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".sel"}, 32'(sel), 32'(es));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    rel = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Hold req, release each tenure after one GRANT cycle, expect a grant order.
  task automatic rr_sequence(input string tag, input logic [5:0] r, input int order[]);
    req = r;
    tick();
    foreach (order[i]) begin
      check_out($sformatf("%s.grant%0d", tag, i), 6'(1) << order[i], 3'(order[i]), 1'b1, 1'b0);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      check_out($sformatf("%s.turn%0d", tag, i), 6'b0, 3'(order[i]), 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    // Reset state while rst is held.
    #2;
    check_out("reset", 6'b0, 3'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_out("idle", 6'b0, 3'd0, 1'b0, 1'b0);

    // Single requester 0, release in GRANT cycle 3, re-grant after TURN.
    req = 6'b000001;
    tick();
    check_out("t1.g1", 6'b000001, 3'd0, 1'b1, 1'b0);
    tick();
    check_out("t1.g2", 6'b000001, 3'd0, 1'b1, 1'b0);
    tick();
    check_out("t1.g3", 6'b000001, 3'd0, 1'b1, 1'b0);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    check_out("t1.turn", 6'b0, 3'd0, 1'b0, 1'b0);
    tick();
    check_out("t1.regrant", 6'b000001, 3'd0, 1'b1, 1'b0);
    req = 6'b0;
    tick();
    check_out("t1.drop_turn", 6'b0, 3'd0, 1'b0, 1'b0);
    tick();
    check_out("t1.idle", 6'b0, 3'd0, 1'b0, 1'b0);

    // All sources requesting: strict rotation 0..5 then wrap.
    apply_reset();
    rr_sequence("t2", 6'b111111, '{0, 1, 2, 3, 4, 5, 0});

    // Sources 0 and 5 alternate.
    apply_reset();
    rr_sequence("t3", 6'b100001, '{0, 5, 0, 5});

    // Source 2 alone with no release: 8 GRANT cycles, timeout, re-grant.
    apply_reset();
    req = 6'b000100;
    tick();
    for (int c = 0; c < 8; c++) begin
      check_out($sformatf("t4.hold%0d", c), 6'b000100, 3'd2, 1'b1, 1'b0);
      tick();
    end
    check_out("t4.timeout", 6'b0, 3'd2, 1'b0, 1'b1);
    tick();
    check_out("t4.regrant", 6'b000100, 3'd2, 1'b1, 1'b0);

    // Owner 3 drops its request while source 4 waits.
    apply_reset();
    req = 6'b001000;
    tick();
    check_out("t5.g3", 6'b001000, 3'd3, 1'b1, 1'b0);
    req = 6'b011000;
    tick();
    check_out("t5.other_req", 6'b001000, 3'd3, 1'b1, 1'b0);
    req = 6'b010000;
    tick();
    check_out("t5.turn", 6'b0, 3'd3, 1'b0, 1'b0);
    tick();
    check_out("t5.g4", 6'b010000, 3'd4, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a tenure of source 4.
    apply_reset();
    req = 6'b010000;
    tick();
    check_out("t6.g4", 6'b010000, 3'd4, 1'b1, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    check_out("t6.async_rst", 6'b0, 3'd0, 1'b0, 1'b0);
    req = 6'b010001;
    tick();
    rst = 1'b0;
    tick();
    check_out("t6.first_grant", 6'b000001, 3'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
